// File: rtl/alu_control_md.sv
// ALU control for the single-cycle MIPS core: combinational aluOp/funct decode
// plus an iterative HI/LO multiply/divide sequencer that stalls fetch while busy.
//
// state | meaning
// IDLE  | no mul/div in flight; a valid mult/multu/div/divu starts here
// BUSY  | one shift-add or restoring shift-subtract step per cycle, count 0..WIDTH-1
module alu_control_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [5:0]       funct,
    input  logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       ctrl,
    output logic             JR,
    output logic             hilo_rd,
    output logic [WIDTH-1:0] hilo_data,
    output logic             stall,
    output logic             busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] work_q, work_d;   // {acc/remainder, multiplier/quotient}
    logic [WIDTH-1:0]   opnd_q;           // multiplicand or divisor magnitude
    logic               is_div_q, neg_res_q, neg_rem_q, div0_q;

    logic               is_muldiv, start;
    logic               signed_op, is_div, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, mul_res;
    logic [WIDTH-1:0]   quo, rem, hi_d, lo_d;

    // Decode of aluOp/funct into ALU select, JR and HI/LO read.
    always_comb begin
        ctrl      = 4'b0000;
        JR        = 1'b0;
        hilo_rd   = 1'b0;
        is_muldiv = 1'b0;
        case (aluOp)
            3'b100: begin
                case (funct)
                    6'd8:  JR   = 1'b1;
                    6'd0:  ctrl = 4'b1000;
                    6'd2:  ctrl = 4'b1001;
                    6'd3:  ctrl = 4'b1010;
                    6'd32: ctrl = 4'b0010;
                    6'd34: ctrl = 4'b0110;
                    6'd36: ctrl = 4'b0000;
                    6'd37: ctrl = 4'b0001;
                    6'd38: ctrl = 4'b1111;
                    6'd39: ctrl = 4'b1100;
                    6'd42: ctrl = 4'b0111;
                    6'd16, 6'd18: hilo_rd = 1'b1;
                    6'd24, 6'd25, 6'd26, 6'd27: is_muldiv = 1'b1;
                    default: ;
                endcase
            end
            3'b010:  ctrl = 4'b0010;
            3'b110:  ctrl = 4'b0110;
            3'b000:  ctrl = 4'b0000;
            3'b001:  ctrl = 4'b0001;
            3'b111:  ctrl = 4'b1111;
            3'b011:  ctrl = 4'b0111;
            3'b101:  ctrl = 4'b1011;
            default: ;
        endcase
    end

    // Operand magnitudes, one iteration step of each algorithm, and the final signed fix-up.
    always_comb begin
        signed_op = ~funct[0];
        is_div    = funct[1];
        neg_a     = signed_op & src_a[WIDTH-1];
        neg_b     = signed_op & src_b[WIDTH-1];
        mag_a     = neg_a ? -src_a : src_a;
        mag_b     = neg_b ? -src_b : src_b;

        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};

        // remainder stays below the divisor, so bit WIDTH of the difference is the borrow
        div_shift = work_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};

        work_d    = is_div_q ? div_next : mul_next;

        mul_res   = neg_res_q ? -mul_next : mul_next;
        quo       = div_next[WIDTH-1:0];
        rem       = div_next[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            // with a zero divisor the remainder path already returns the dividend
            hi_d = neg_rem_q ? -rem : rem;
            lo_d = div0_q ? '1 : (neg_res_q ? -quo : quo);
        end else begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
        end
    end

    assign start     = valid_in & is_muldiv & (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign stall     = start | (busy & (count_q != LAST));
    assign hilo_data = (aluOp == 3'b100 && funct == 6'd16) ? hi_q : lo_q;

    // Sequencer: latch operands on start, iterate WIDTH steps, commit HI/LO together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q    <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                        opnd_q    <= is_div ? mag_b : mag_a;
                        is_div_q  <= is_div;
                        neg_res_q <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
                        div0_q    <= (src_b == '0);
                        count_q   <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    work_q  <= work_d;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        count_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
